rram_phase_seq: RTL and testbench
=================================

RRAM_PHASE_SEQ -- requirements
Module: rram_phase_seq

Interface
REQ-001 SHALL have parameter NCH, default 4: number of column-group channels.
REQ-002 SHALL have parameter CW, default 6: width of every phase-duration field.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port REQ, input, 1: start request, sampled only in IDLE.
REQ-006 SHALL have port OP, input, 1: operation select, 0 = read, 1 = write; captured with REQ.
REQ-007 SHALL have port CH_SEL, input, NCH: channel enable mask; captured with REQ.
REQ-008 SHALL have ports T_PRE, T_DVLP, T_SA, T_WR, input, CW each: phase durations in cycles; captured with REQ.
REQ-009 SHALL have port DUMMY_EN, input, 1: when low, all phase outputs are forced inactive; the FSM still runs.
REQ-010 SHALL have ports PRE_L, DVLP_L, SA_EN_L, output, 1 each: read-phase strobes.
REQ-011 SHALL have ports WRITE_L and NOT_WRITE_L, output, NCH each: per-channel write strobe and its complement.
REQ-012 SHALL have ports READ_L and NOT_READ_L, output, NCH each: per-channel read window and its complement.
REQ-013 SHALL have ports BUSY, DONE and ERR, output, 1 each: sequencer status; DONE and ERR are single-cycle pulses.

Function
REQ-014 SHALL implement the FSM states IDLE, PRE, DVLP, SENSE, WRITE, DONE.
REQ-015 SHALL, on REQ=1 in IDLE with CH_SEL!=0 at edge k, enter PRE (read) or WRITE (write) at edge k+1.
REQ-016 SHALL, on REQ=1 in IDLE with CH_SEL==0, stay in IDLE and pulse ERR for 1 cycle.
REQ-017 SHALL follow the read path PRE -> DVLP -> SENSE -> DONE -> IDLE.
REQ-018 SHALL follow the write path WRITE -> DONE -> IDLE.
REQ-019 SHALL hold each phase state exactly max(T_x,1) cycles, counted by a CW-bit down-counter; a duration of 0 is treated as 1.
REQ-020 SHALL register all outputs, so each output is a 1-cycle-delayed decode of the state.
REQ-021 SHALL assert PRE_L only during PRE and DVLP_L only during DVLP.
REQ-022 SHALL assert SA_EN_L only during SENSE.
REQ-023 SHALL assert READ_L[i] = CH_SEL[i] throughout PRE, DVLP and SENSE.
REQ-024 SHALL assert WRITE_L[i] = CH_SEL[i] during WRITE.
REQ-025 SHALL keep every NOT_* output the exact bitwise inverse of its partner on every cycle.
REQ-026 SHALL hold BUSY=1 in every state except IDLE.
REQ-027 SHALL pulse DONE for the single cycle spent in DONE.
REQ-028 SHALL ignore REQ whenever the FSM is not in IDLE; a request must not be queued.
REQ-029 SHALL accept a new REQ in the cycle after DONE.
REQ-030 SHALL treat a DUMMY_EN change mid-operation as taking effect on the next output register update.

Reset
REQ-031 SHALL, while RST_N=0 (including mid-operation), force state=IDLE and counter=0.
REQ-032 SHALL, while RST_N=0, drive all strobes, BUSY, DONE and ERR to 0 and all NOT_* outputs to all-ones, then resume on the first edge after release.

Configuration
REQ-033 SHALL, with RRAM_SEQ_GUARD_EN defined, insert one GUARD cycle with all strobes inactive (BUSY=1) between consecutive phases and before DONE.
REQ-034 SHALL, without RRAM_SEQ_GUARD_EN, run phases back-to-back with no GUARD state present.

Structure
REQ-035 SHALL take the state encoding typedef, the OP_READ and OP_WRITE constants and the defaults for NCH and CW from the shared package rram_ctrl_pkg.
REQ-036 SHALL place the phase down-counter (load, zero-clamp, terminal flag) in the sub-module rram_phase_cnt.

Verification
REQ-037 SHALL cover a read with NCH=4, CH_SEL=4'b0101, T_PRE=2, T_DVLP=3, T_SA=1: expect PRE_L for 2 cycles, DVLP_L for 3, SA_EN_L for 1, READ_L=0101 for those 6 cycles, then DONE for 1 cycle (no guard).
REQ-038 SHALL cover a write with CH_SEL=4'b1000, T_WR=0: expect WRITE_L=1000 and NOT_WRITE_L=0111 for 1 cycle, then DONE.
REQ-039 SHALL cover REQ with CH_SEL=0: expect ERR for 1 cycle and BUSY staying 0.
REQ-040 SHALL cover REQ pulsed during DVLP: expect the sequence unchanged and no second operation started.
REQ-041 SHALL cover RST_N=0 mid-SENSE: expect all strobes 0 and NOT_* all-ones immediately, with IDLE after release.
REQ-042 SHALL cover the guard build (RRAM_SEQ_GUARD_EN defined) with the REQ-037 stimulus: expect 1 all-inactive cycle between each phase and before DONE, and BUSY high throughout.

Source files
------------

// File: rtl/rram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rram_ctrl_pkg
// Description : Shared definitions for the RRAM phase sequencer: sequencer
//               state encoding, operation codes and default widths.
//               RRAM_SEQ_GUARD_EN adds a GUARD state to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rram_ctrl_pkg;

  localparam int unsigned NCH_DEF = 4;  // column-group channels
  localparam int unsigned CW_DEF  = 6;  // phase-duration field width

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DVLP  = 3'd2,
    ST_SENSE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
`ifdef RRAM_SEQ_GUARD_EN
    ,
    ST_GUARD = 3'd6
`endif
  } seq_state_t;

endpackage : rram_ctrl_pkg
`default_nettype wire

// File: rtl/rram_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rram_phase_cnt
// Description : Phase duration down-counter. A load of 0 is clamped to 1 so
//               every phase lasts at least one cycle; 'last' flags the final
//               cycle of the current phase.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               load, load_val  - (re)start the count with a raw duration
//               last            - current cycle is the last of the phase
// Revision    : 1.0 - initial release
// ============================================================================
module rram_phase_cnt
  import rram_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  localparam logic [CW-1:0] c_one = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_load_clamped;

  assign w_load_clamped = (load_val == '0) ? c_one : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= w_load_clamped;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  // <= rather than == so a stray zero count can never stall a phase
  assign last = (r_cnt <= c_one);

endmodule : rram_phase_cnt
`default_nettype wire

// File: rtl/rram_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : rram_phase_seq
// Description : RRAM read/write phase sequencer. Read runs PRE -> DVLP ->
//               SENSE -> DONE, write runs WRITE -> DONE; each phase lasts
//               max(T,1) cycles. All outputs are registered decodes of the
//               state (one cycle behind it). Define RRAM_SEQ_GUARD_EN to put
//               one all-inactive GUARD cycle between phases and before DONE.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req, op, ch_sel            - request, 0=read/1=write, mask
//               t_pre,t_dvlp,t_sa,t_wr     - phase durations in cycles
//               dummy_en                   - low forces phase strobes off
//               pre_l, dvlp_l, sa_en_l     - read phase strobes
//               write_l/not_write_l        - per-channel write strobe pair
//               read_l/not_read_l          - per-channel read window pair
//               busy, done, err            - status (done/err are pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module rram_phase_seq
  import rram_ctrl_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           op,
  input  logic [NCH-1:0] ch_sel,
  input  logic [CW-1:0]  t_pre,
  input  logic [CW-1:0]  t_dvlp,
  input  logic [CW-1:0]  t_sa,
  input  logic [CW-1:0]  t_wr,
  input  logic           dummy_en,
  output logic           pre_l,
  output logic           dvlp_l,
  output logic           sa_en_l,
  output logic [NCH-1:0] write_l,
  output logic [NCH-1:0] not_write_l,
  output logic [NCH-1:0] read_l,
  output logic [NCH-1:0] not_read_l,
  output logic           busy,
  output logic           done,
  output logic           err
);

  seq_state_t     r_state, w_next;
  seq_state_t     w_tgt;
  logic [CW-1:0]  w_tgt_dur;
  logic           w_adv;
  logic           w_load;
  logic [CW-1:0]  w_load_val;
  logic           w_last;
  logic           w_accept;
  logic           w_err;

  logic [NCH-1:0] r_ch_sel;
  logic [CW-1:0]  r_t_dvlp;
  logic [CW-1:0]  r_t_sa;

  logic           r_pre_l, r_dvlp_l, r_sa_en_l;
  logic [NCH-1:0] r_write_l, r_read_l;
  logic           r_busy, r_done, r_err;

`ifdef RRAM_SEQ_GUARD_EN
  // Phase to enter once the guard cycle has elapsed, and its duration
  seq_state_t     r_after;
  logic [CW-1:0]  r_after_dur;
`endif

  assign w_accept = (r_state == ST_IDLE) && req && (ch_sel != '0);
  assign w_err    = (r_state == ST_IDLE) && req && (ch_sel == '0);

  rram_phase_cnt #(.CW(CW)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: each phase names its successor (w_tgt); the common tail
  // either jumps there directly or detours through GUARD.
  always_comb begin
    w_next     = r_state;
    w_tgt      = ST_DONE;
    w_tgt_dur  = '0;
    w_adv      = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (op == OP_WRITE) begin
            w_next     = ST_WRITE;
            w_load_val = t_wr;
          end else begin
            w_next     = ST_PRE;
            w_load_val = t_pre;
          end
        end
      end
      ST_PRE: begin
        w_adv     = w_last;
        w_tgt     = ST_DVLP;
        w_tgt_dur = r_t_dvlp;
      end
      ST_DVLP: begin
        w_adv     = w_last;
        w_tgt     = ST_SENSE;
        w_tgt_dur = r_t_sa;
      end
      ST_SENSE: begin
        w_adv = w_last;
      end
      ST_WRITE: begin
        w_adv = w_last;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
`ifdef RRAM_SEQ_GUARD_EN
      ST_GUARD: begin
        w_next     = r_after;
        w_load     = 1'b1;
        w_load_val = r_after_dur;
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    if (w_adv) begin
`ifdef RRAM_SEQ_GUARD_EN
      w_next = ST_GUARD;
`else
      w_next     = w_tgt;
      w_load     = 1'b1;
      w_load_val = w_tgt_dur;
`endif
    end
  end

`ifdef RRAM_SEQ_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_after     <= ST_IDLE;
      r_after_dur <= '0;
    end else if (w_adv) begin
      r_after     <= w_tgt;
      r_after_dur <= w_tgt_dur;
    end
  end
`endif

  // Operation parameters latched at acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_sel <= '0;
      r_t_dvlp <= '0;
      r_t_sa   <= '0;
    end else if (w_accept) begin
      r_ch_sel <= ch_sel;
      r_t_dvlp <= t_dvlp;
      r_t_sa   <= t_sa;
    end
  end

  // Registered output decode of the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_l   <= 1'b0;
      r_dvlp_l  <= 1'b0;
      r_sa_en_l <= 1'b0;
      r_write_l <= '0;
      r_read_l  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_pre_l   <= dummy_en && (r_state == ST_PRE);
      r_dvlp_l  <= dummy_en && (r_state == ST_DVLP);
      r_sa_en_l <= dummy_en && (r_state == ST_SENSE);
      r_read_l  <= (dummy_en && ((r_state == ST_PRE) || (r_state == ST_DVLP) ||
                                 (r_state == ST_SENSE))) ? r_ch_sel : '0;
      r_write_l <= (dummy_en && (r_state == ST_WRITE)) ? r_ch_sel : '0;
      r_busy    <= (r_state != ST_IDLE);
      r_done    <= (r_state == ST_DONE);
      r_err     <= w_err;
    end
  end

  assign pre_l       = r_pre_l;
  assign dvlp_l      = r_dvlp_l;
  assign sa_en_l     = r_sa_en_l;
  assign write_l     = r_write_l;
  assign not_write_l = ~r_write_l;
  assign read_l      = r_read_l;
  assign not_read_l  = ~r_read_l;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule : rram_phase_seq
`default_nettype wire

// File: tb/tb_rram_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rram_phase_seq
// Description : Self-checking bench for rram_phase_seq. Operations come from
//               a vector table; the expected per-cycle output trace of each
//               operation is queued when the request is driven and popped
//               and compared every cycle. Hand-written sequences cover a
//               request during DVLP and reset during SENSE. Honours
//               RRAM_SEQ_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rram_phase_seq;

  localparam int NCH = 4;
  localparam int CW  = 6;

  // trace phase codes
  localparam int c_ph_idle  = 0;
  localparam int c_ph_pre   = 1;
  localparam int c_ph_dvlp  = 2;
  localparam int c_ph_sa    = 3;
  localparam int c_ph_wr    = 4;
  localparam int c_ph_guard = 5;
  localparam int c_ph_done  = 6;

`ifdef RRAM_SEQ_GUARD_EN
  localparam int c_gd_rd = 3;
  localparam int c_gd_wr = 1;
`else
  localparam int c_gd_rd = 0;
  localparam int c_gd_wr = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req;
  logic           op;
  logic [NCH-1:0] ch_sel;
  logic [CW-1:0]  t_pre, t_dvlp, t_sa, t_wr;
  logic           dummy_en;
  logic           pre_l, dvlp_l, sa_en_l;
  logic [NCH-1:0] write_l, not_write_l, read_l, not_read_l;
  logic           busy, done, err;

  always #5 clk = ~clk;

  rram_phase_seq #(.NCH(NCH), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .op          (op),
    .ch_sel      (ch_sel),
    .t_pre       (t_pre),
    .t_dvlp      (t_dvlp),
    .t_sa        (t_sa),
    .t_wr        (t_wr),
    .dummy_en    (dummy_en),
    .pre_l       (pre_l),
    .dvlp_l      (dvlp_l),
    .sa_en_l     (sa_en_l),
    .write_l     (write_l),
    .not_write_l (not_write_l),
    .read_l      (read_l),
    .not_read_l  (not_read_l),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  logic [21:0] dut_word;
  assign dut_word = {pre_l, dvlp_l, sa_en_l, write_l, not_write_l,
                     read_l, not_read_l, busy, done, err};

  typedef struct {
    string          name;
    logic           op;
    logic [NCH-1:0] ch;
    logic [CW-1:0]  tp, td, ts, tw;
    logic           dm;
    int             exp_busy;  // busy cycles without guard cycles
  } vec_t;

  vec_t        vecs[9];
  logic [21:0] sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [21:0] exp_word(int ph, logic [NCH-1:0] ch,
                                           logic dm, logic er);
    logic           p, d, s, b, dn;
    logic [NCH-1:0] rd, wr;
    p  = dm && (ph == c_ph_pre);
    d  = dm && (ph == c_ph_dvlp);
    s  = dm && (ph == c_ph_sa);
    rd = (dm && (ph == c_ph_pre || ph == c_ph_dvlp || ph == c_ph_sa)) ? ch : '0;
    wr = (dm && (ph == c_ph_wr)) ? ch : '0;
    b  = (ph != c_ph_idle);
    dn = (ph == c_ph_done);
    return {p, d, s, wr, ~wr, rd, ~rd, b, dn, er};
  endfunction

  function automatic int dur(logic [CW-1:0] t);
    return (t == '0) ? 1 : int'(t);
  endfunction

  task automatic push_n(int ph, int n, vec_t v);
    for (int i = 0; i < n; i++) sb.push_back(exp_word(ph, v.ch, v.dm, 1'b0));
  endtask

  task automatic push_guard(vec_t v);
`ifdef RRAM_SEQ_GUARD_EN
    push_n(c_ph_guard, 1, v);
`else
    if (v.dm === 1'bx) push_n(c_ph_guard, 0, v);
`endif
  endtask

  // Expected outputs sampled after each edge, starting with the edge that
  // samples the request.
  task automatic push_trace(vec_t v);
    if (v.ch == '0) begin
      sb.push_back(exp_word(c_ph_idle, v.ch, v.dm, 1'b1));
      return;
    end
    push_n(c_ph_idle, 1, v);
    if (v.op == 1'b0) begin
      push_n(c_ph_pre, dur(v.tp), v);
      push_guard(v);
      push_n(c_ph_dvlp, dur(v.td), v);
      push_guard(v);
      push_n(c_ph_sa, dur(v.ts), v);
    end else begin
      push_n(c_ph_wr, dur(v.tw), v);
    end
    push_guard(v);
    push_n(c_ph_done, 1, v);
  endtask

  task automatic check_w(string name, logic [21:0] got, logic [21:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_i(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drives one request, then pops/compares the queued trace each cycle.
  // inject_at: sample index after which a stray request is pulsed.
  // abort_at : sample index after which checking stops (trace left queued).
  task automatic run_op(vec_t v, int inject_at, int abort_at, int extra_idle,
                        output int busy_seen);
    int n;
    n         = 0;
    busy_seen = 0;
    op       = v.op;
    ch_sel   = v.ch;
    t_pre    = v.tp;
    t_dvlp   = v.td;
    t_sa     = v.ts;
    t_wr     = v.tw;
    dummy_en = v.dm;
    req      = 1'b1;
    push_trace(v);
    push_n(c_ph_idle, extra_idle, v);
    while (sb.size() > 0) begin
      @(negedge clk);
      req = (n == inject_at);
      if (n == inject_at) begin
        op     = ~v.op;
        ch_sel = ~v.ch;
      end
      check_w($sformatf("%s[%0d]", v.name, n), dut_word, sb.pop_front());
      busy_seen += int'(busy);
      if (n == abort_at) break;
      n++;
      if (n > 300) begin
        n_fail++;
        $display("FAIL %s timeout: got %0d samples expected trace end", v.name, n);
        sb.delete();
      end
    end
  endtask

  logic [21:0] c_rst_word;
  int          bs;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rd_0101",   1'b0, 4'b0101, 6'd2, 6'd3, 6'd1, 6'd0,  1'b1, 7};
    vecs[1] = '{"wr_1000",   1'b1, 4'b1000, 6'd0, 6'd0, 6'd0, 6'd0,  1'b1, 2};
    vecs[2] = '{"err_ch0",   1'b0, 4'b0000, 6'd2, 6'd2, 6'd2, 6'd2,  1'b1, 0};
    vecs[3] = '{"rd_1111",   1'b0, 4'b1111, 6'd0, 6'd1, 6'd4, 6'd0,  1'b1, 7};
    vecs[4] = '{"wr_0110",   1'b1, 4'b0110, 6'd0, 6'd0, 6'd0, 6'd3,  1'b1, 4};
    vecs[5] = '{"rd_dummy0", 1'b0, 4'b0011, 6'd2, 6'd2, 6'd2, 6'd0,  1'b0, 7};
    vecs[6] = '{"wr_dummy0", 1'b1, 4'b1111, 6'd0, 6'd0, 6'd0, 6'd2,  1'b0, 3};
    vecs[7] = '{"rd_zeros",  1'b0, 4'b1000, 6'd0, 6'd0, 6'd0, 6'd0,  1'b1, 4};
    vecs[8] = '{"wr_max",    1'b1, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd63, 1'b1, 64};

    c_rst_word = {3'b000, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 3'b000};

    rst_n = 1'b0; req = 1'b0; op = 1'b0; ch_sel = '0;
    t_pre = '0; t_dvlp = '0; t_sa = '0; t_wr = '0; dummy_en = 1'b1;
    repeat (3) @(negedge clk);
    check_w("reset", dut_word, c_rst_word);
    rst_n = 1'b1;
    @(negedge clk);
    check_w("post_reset_idle", dut_word, c_rst_word);

    // Table: traces end on DONE, so each next request lands in the cycle
    // right after DONE.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], -1, -1, 0, bs);
      check_i({vecs[i].name, "_busy_cycles"}, bs,
              vecs[i].exp_busy + ((vecs[i].ch == '0) ? 0 :
                                  (vecs[i].op ? c_gd_wr : c_gd_rd)));
    end

    // Stray request during DVLP: trace unchanged, then idle, no second op
    run_op(vecs[0], 3, -1, 4, bs);
    check_i("inject_busy_cycles", bs, 7 + c_gd_rd);

    // Reset asserted while SENSE is visible
    begin
      vec_t vr;
      vr = '{"rd_rst", 1'b0, 4'b1010, 6'd1, 6'd1, 6'd5, 6'd0, 1'b1, 0};
`ifdef RRAM_SEQ_GUARD_EN
      run_op(vr, -1, 6, 0, bs);
`else
      run_op(vr, -1, 4, 0, bs);
`endif
      check_i("rst_sa_seen", int'(sa_en_l), 1);
      sb.delete();
      rst_n = 1'b0;
      #1;
      check_w("rst_mid_sense", dut_word, c_rst_word);
      @(negedge clk);
      check_w("rst_held", dut_word, c_rst_word);
      rst_n = 1'b1;
      @(negedge clk);
      check_w("rst_release_idle", dut_word, c_rst_word);
      @(negedge clk);
      check_w("rst_release_idle2", dut_word, c_rst_word);
    end

    // Resumes normally after reset
    run_op(vecs[1], -1, -1, 2, bs);
    check_i("after_rst_busy_cycles", bs, 2 + c_gd_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rram_phase_seq
`default_nettype wire
